// File: rtl/idmem_bridge_pkg.sv
// Shared types for the fetch/data to sram-like bus bridge.
package idmem_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        D_ADDR,
        D_DATA,
        I_ADDR,
        I_DATA
    } bridge_state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Stall sources handed to the hazard unit.
    typedef struct packed {
        logic imem;
        logic dmem;
    } busy_ok_t;

endpackage

// File: rtl/idmem_bridge_done.sv
// Per-port completion tracker: done flag, returned-data register and the
// same-cycle bypass of the bus response.
module req_done_tracker #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              hold,
    input  logic              clear,
    input  logic              capture,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              done,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            done    <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (capture) begin
                rdata_q <= bus_rdata;
            end
            // A held stage keeps the completed result until it advances.
            if (clear) begin
                done <= 1'b0;
            end else if (capture) begin
                done <= hold;
            end else if (!hold) begin
                done <= 1'b0;
            end
        end
    end

    assign rdata = capture ? bus_rdata : rdata_q;

endmodule

// File: rtl/idmem_bridge.sv
// Single-outstanding bridge from the F-stage fetch port and M-stage data
// port onto one sram-like bus; data wins arbitration.
module idmem_bridge
    import idmem_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_hold,
    input  logic              inst_cancel,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    input  logic              data_hold,
    output logic [DATA_W-1:0] data_rdata,
    output logic              imem_busy,
    output logic              dmem_busy,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    bridge_state_t state;
    logic          stale;
    logic          d_done;
    logic          i_done;
    logic          d_ack;
    logic          i_ack;
    busy_ok_t      busy;

    assign d_ack = (state == D_DATA) && bus_data_ok;
    assign i_ack = (state == I_DATA) && bus_data_ok;

    assign busy.dmem = data_req && !d_done && !d_ack;
    assign busy.imem = inst_req && !i_done && !(i_ack && !stale);
    assign dmem_busy = busy.dmem;
    assign imem_busy = busy.imem;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            bus_req   <= 1'b0;
            bus_wr    <= 1'b0;
            bus_size  <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            stale     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_req && !d_done) begin
                        state     <= D_ADDR;
                        bus_req   <= 1'b1;
                        bus_wr    <= data_wr;
                        bus_size  <= data_size;
                        bus_addr  <= data_addr;
                        bus_wdata <= data_wdata;
                    end else if (inst_req && !i_done) begin
                        state     <= I_ADDR;
                        bus_req   <= 1'b1;
                        bus_wr    <= 1'b0;
                        bus_size  <= SZ_WORD;
                        bus_addr  <= inst_addr;
                        bus_wdata <= '0;
                    end
                end
                D_ADDR: begin
                    if (bus_addr_ok) begin
                        state   <= D_DATA;
                        bus_req <= 1'b0;
                    end
                end
                I_ADDR: begin
                    if (bus_addr_ok) begin
                        state   <= I_DATA;
                        bus_req <= 1'b0;
                    end
                    if (inst_cancel) begin
                        stale <= 1'b1;
                    end
                end
                D_DATA: begin
                    if (bus_data_ok) begin
                        state <= IDLE;
                    end
                end
                I_DATA: begin
                    // The response closing the transaction always drains stale.
                    if (bus_data_ok) begin
                        state <= IDLE;
                        stale <= 1'b0;
                    end else if (inst_cancel) begin
                        stale <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    req_done_tracker #(.DATA_W(DATA_W)) u_data_done (
        .clk       (clk),
        .resetn    (resetn),
        .hold      (data_hold),
        .clear     (1'b0),
        .capture   (d_ack),
        .bus_rdata (bus_rdata),
        .done      (d_done),
        .rdata     (data_rdata)
    );

    req_done_tracker #(.DATA_W(DATA_W)) u_inst_done (
        .clk       (clk),
        .resetn    (resetn),
        .hold      (inst_hold),
        .clear     (inst_cancel && (state == IDLE)),
        .capture   (i_ack && !stale),
        .bus_rdata (bus_rdata),
        .done      (i_done),
        .rdata     (inst_rdata)
    );

endmodule

// File: tb/tb_idmem_bridge.sv
// Scoreboard bench for idmem_bridge with a small sram-like slave model.
module tb_idmem_bridge;
    import idmem_bridge_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          resetn;
    logic          inst_req, inst_hold, inst_cancel;
    logic [AW-1:0] inst_addr;
    logic [DW-1:0] inst_rdata;
    logic          data_req, data_wr, data_hold;
    logic [1:0]    data_size;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata, data_rdata;
    logic          imem_busy, dmem_busy;
    logic          bus_req, bus_wr;
    logic [1:0]    bus_size;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_addr_ok, bus_data_ok;
    logic [DW-1:0] bus_rdata;

    always #5 clk = ~clk;

    idmem_bridge #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_hold   (inst_hold),
        .inst_cancel (inst_cancel),
        .inst_rdata  (inst_rdata),
        .data_req    (data_req),
        .data_wr     (data_wr),
        .data_size   (data_size),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_hold   (data_hold),
        .data_rdata  (data_rdata),
        .imem_busy   (imem_busy),
        .dmem_busy   (dmem_busy),
        .bus_req     (bus_req),
        .bus_wr      (bus_wr),
        .bus_size    (bus_size),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_addr_ok (bus_addr_ok),
        .bus_data_ok (bus_data_ok),
        .bus_rdata   (bus_rdata)
    );

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_txn_t;

    bus_txn_t    exp_bus_q[$];
    logic [31:0] exp_d_q[$];
    logic [31:0] exp_i_q[$];
    logic [31:0] rsp_q[$];

    int tests = 0;
    int fails = 0;

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Slave: addr_ok after addr_wait cycles of bus_req, data_ok data_lat+1 cycles later.
    int          addr_wait = 0;
    int          data_lat  = 0;
    int          acnt = 0, dcnt = 0;
    int          wr_count = 0, accepts = 0, req_cycles = 0;
    bit          pend = 0, spurious = 0;
    logic        rst_seen;
    logic [31:0] cur_rsp;

    initial begin
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = 32'h0BAD0BAD;
        forever begin
            @(posedge clk);
            rst_seen = resetn;
            #1;
            bus_addr_ok = 1'b0;
            bus_data_ok = 1'b0;
            bus_rdata   = 32'h0BAD0BAD;
            if (rst_seen !== 1'b1) begin
                pend = 0;
                acnt = 0;
            end else if (pend) begin
                if (dcnt == 0) begin
                    bus_data_ok = 1'b1;
                    bus_rdata   = cur_rsp;
                    pend        = 0;
                end else begin
                    dcnt--;
                end
            end else if (bus_req) begin
                if (acnt < addr_wait) begin
                    acnt++;
                end else begin
                    bus_addr_ok = 1'b1;
                    acnt = 0;
                    pend = 1;
                    dcnt = data_lat;
                    accepts++;
                    if (bus_wr) wr_count++;
                    cur_rsp = (rsp_q.size() != 0) ? rsp_q.pop_front() : 32'h0;
                end
            end else if (spurious) begin
                bus_data_ok = 1'b1;
                bus_rdata   = 32'h5A5A5A5A;
            end
        end
    end

    // Monitor: pops expected bus requests and stage results as the DUT presents them.
    always @(negedge clk) begin
        bus_txn_t got;
        if (resetn === 1'b1) begin
            if (bus_req) begin
                req_cycles++;
                got = {bus_wr, bus_size, bus_addr, bus_wdata};
                if (exp_bus_q.size() == 0) check("bus_req_unexpected", 1, 0);
                else if (bus_addr_ok)      check("bus_accept", got, exp_bus_q.pop_front());
                else                       check("bus_stable", got, exp_bus_q[0]);
            end
            if (data_req && !dmem_busy && !data_hold) begin
                if (exp_d_q.size() == 0) check("data_unexpected", 1, 0);
                else                     check("data_rdata", data_rdata, exp_d_q.pop_front());
            end
            if (inst_req && !imem_busy && !inst_hold) begin
                if (exp_i_q.size() == 0) check("inst_unexpected", 1, 0);
                else                     check("inst_rdata", inst_rdata, exp_i_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_data(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, input int hold_cycles, output int busy_cyc);
        int n;
        data_req = 1'b1; data_wr = wr; data_size = size;
        data_addr = addr; data_wdata = wdata; data_hold = (hold_cycles > 0);
        n = 0;
        @(negedge clk);
        while (dmem_busy && n < 60) begin
            n++;
            step();
            @(negedge clk);
        end
        busy_cyc = n;
        if (dmem_busy) check("data_timeout", 1, 0);
        for (int i = 0; i < hold_cycles; i++) begin
            step();
            @(negedge clk);
            check("dmem_busy_held", dmem_busy, 0);
        end
        if (hold_cycles > 0) begin
            step();
            data_hold = 1'b0;
            @(negedge clk);
            check("dmem_busy_release", dmem_busy, 0);
        end
        step();
        data_req = 1'b0;
        data_hold = 1'b0;
    endtask

    task automatic run_inst(input logic [31:0] addr, input int hold_cycles, output int busy_cyc);
        int n;
        inst_req = 1'b1; inst_addr = addr; inst_hold = (hold_cycles > 0);
        n = 0;
        @(negedge clk);
        while (imem_busy && n < 60) begin
            n++;
            step();
            @(negedge clk);
        end
        busy_cyc = n;
        if (imem_busy) check("inst_timeout", 1, 0);
        for (int i = 0; i < hold_cycles; i++) begin
            step();
            @(negedge clk);
            check("imem_busy_held", imem_busy, 0);
        end
        if (hold_cycles > 0) begin
            step();
            inst_hold = 1'b0;
            @(negedge clk);
            check("imem_busy_release", imem_busy, 0);
        end
        step();
        inst_req = 1'b0;
        inst_hold = 1'b0;
    endtask

    initial begin
        int dcyc, icyc, w0, a0, r0, n;
        bit timed_out;
        resetn = 1'b0;
        inst_req = 0; inst_hold = 0; inst_cancel = 0; inst_addr = '0;
        data_req = 0; data_wr = 0; data_hold = 0; data_size = '0;
        data_addr = '0; data_wdata = '0;
        repeat (3) step();
        resetn = 1'b1;
        @(negedge clk);
        check("rst_bus_req", bus_req, 0);
        check("rst_bus_fields", {bus_wr, bus_size, bus_addr, bus_wdata}, 0);
        check("rst_rdata", {inst_rdata, data_rdata}, 0);
        check("rst_busy", {imem_busy, dmem_busy}, 0);
        step();

        // Minimum-latency load.
        exp_bus_q.push_back('{1'b0, SZ_WORD, 32'h100, 32'h0});
        rsp_q.push_back(32'hDEADBEEF);
        exp_d_q.push_back(32'hDEADBEEF);
        r0 = req_cycles;
        run_data(1'b0, SZ_WORD, 32'h100, 32'h0, 0, dcyc);
        check("load_busy_cycles", dcyc, 2);
        check("load_req_cycles", req_cycles - r0, 1);

        // Simultaneous requests: data first, fetch afterwards.
        exp_bus_q.push_back('{1'b1, SZ_BYTE, 32'h208, 32'hAB});
        exp_bus_q.push_back('{1'b0, SZ_WORD, 32'h1000, 32'h0});
        rsp_q.push_back(32'h0);
        rsp_q.push_back(32'h24020001);
        exp_d_q.push_back(32'h0);
        exp_i_q.push_back(32'h24020001);
        fork
            run_data(1'b1, SZ_BYTE, 32'h208, 32'hAB, 0, dcyc);
            run_inst(32'h1000, 0, icyc);
        join
        check("arb_dmem_busy_cycles", dcyc, 2);
        check("arb_imem_busy_cycles", icyc, 5);

        // Held store: exactly one bus write.
        exp_bus_q.push_back('{1'b1, SZ_WORD, 32'h200, 32'h12345678});
        rsp_q.push_back(32'h0);
        exp_d_q.push_back(32'h0);
        w0 = wr_count;
        run_data(1'b1, SZ_WORD, 32'h200, 32'h12345678, 3, dcyc);
        repeat (2) step();
        check("held_store_writes", wr_count - w0, 1);

        // Held fetch: one bus read, result served from the register.
        exp_bus_q.push_back('{1'b0, SZ_WORD, 32'h2000, 32'h0});
        rsp_q.push_back(32'h8C880004);
        exp_i_q.push_back(32'h8C880004);
        a0 = accepts;
        run_inst(32'h2000, 2, icyc);
        repeat (2) step();
        check("held_fetch_reads", accepts - a0, 1);

        // Fetch cancelled while outstanding; stale response dropped.
        data_lat = 2;
        exp_bus_q.push_back('{1'b0, SZ_WORD, 32'h400, 32'h0});
        exp_bus_q.push_back('{1'b0, SZ_WORD, 32'hBFC00380, 32'h0});
        rsp_q.push_back(32'h11111111);
        rsp_q.push_back(32'h22222222);
        exp_i_q.push_back(32'h22222222);
        a0 = accepts;
        inst_req = 1'b1; inst_addr = 32'h400;
        n = 0;
        timed_out = 1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (!imem_busy) begin
                timed_out = 0;
                break;
            end
            n++;
            step();
            if (n == 2) begin
                inst_cancel = 1'b1;
                inst_addr   = 32'hBFC00380;
            end else begin
                inst_cancel = 1'b0;
            end
        end
        if (timed_out) check("cancel_timeout", 1, 0);
        check("cancel_busy_cycles", n, 9);
        step();
        inst_req = 1'b0;
        check("cancel_reads", accepts - a0, 2);
        data_lat = 0;

        // Address phase stretched: fields checked stable by the monitor.
        addr_wait = 5;
        exp_bus_q.push_back('{1'b1, SZ_HALF, 32'h302, 32'h0000CAFE});
        rsp_q.push_back(32'h0);
        exp_d_q.push_back(32'h0);
        run_data(1'b1, SZ_HALF, 32'h302, 32'h0000CAFE, 0, dcyc);
        check("stretch_busy_cycles", dcyc, 7);
        addr_wait = 0;

        // Reset while a load is in its data phase.
        data_lat = 3;
        exp_bus_q.push_back('{1'b0, SZ_WORD, 32'h500, 32'h0});
        rsp_q.push_back(32'h77777777);
        data_req = 1'b1; data_wr = 1'b0; data_size = SZ_WORD;
        data_addr = 32'h500; data_wdata = '0;
        inst_req = 1'b1; inst_addr = 32'h600;
        step();
        step();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        @(negedge clk);
        check("midrst_bus_req", bus_req, 0);
        check("midrst_dmem_busy", dmem_busy, 1);
        check("midrst_imem_busy", imem_busy, 1);
        check("midrst_rdata", {inst_rdata, data_rdata}, 0);
        data_req = 1'b0;
        inst_req = 1'b0;
        data_lat = 0;
        repeat (3) step();
        @(negedge clk);
        check("midrst_idle", bus_req, 0);

        // Response with nothing outstanding must be ignored.
        exp_bus_q.push_back('{1'b0, SZ_WORD, 32'h104, 32'h0});
        rsp_q.push_back(32'hFEEDF00D);
        exp_d_q.push_back(32'hFEEDF00D);
        run_data(1'b0, SZ_WORD, 32'h104, 32'h0, 0, dcyc);
        @(negedge clk);
        spurious = 1;
        @(negedge clk);
        check("spurious_data_ok_seen", bus_data_ok, 1);
        check("spurious_data_rdata", data_rdata, 32'hFEEDF00D);
        check("spurious_inst_rdata", inst_rdata, 32'h0);
        spurious = 0;
        step();
        @(negedge clk);
        check("spurious_no_req", bus_req, 0);

        check("bus_queue_drained", exp_bus_q.size(), 0);
        check("data_queue_drained", exp_d_q.size(), 0);
        check("inst_queue_drained", exp_i_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
